control_sequencer: RTL

//  Multi-cycle fetch/decode/sequence stage directly upstream of the register file.

---
 rtl/control_sequencer_pkg.sv | 34 +++
 rtl/control_sequencer_if.sv | 29 ++
 rtl/control_sequencer_decoder.sv | 19 +
 rtl/control_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared cpu_pkg types, field positions and opcode classification (ILLEGAL_OP_TRAP_EN adds the TRAP state)
package cpu_pkg;
   localparam int PC_W    = 8;
   localparam int INSTR_W = 24;
   localparam int REG_AW  = 5;
   localparam int FLAG_W  = 7;
   localparam int OP_HI   = 23;
   localparam int OP_LO   = 18;
   localparam int RD_HI   = 17;
   localparam int RD_LO   = 13;
   localparam int RS1_HI  = 12;
   localparam int RS1_LO  = 8;
   localparam int RS2_HI  = 4;
   localparam int IMM_HI  = 7;
   localparam logic [5:0] OP_MOV  = 6'h20;
   localparam logic [5:0] OP_JMP  = 6'h21;
   localparam logic [5:0] OP_NOP  = 6'h3E;
   localparam logic [5:0] OP_HALT = 6'h3F;
   typedef enum logic [2:0] {
      FETCH, DECODE, READ, EXEC, WB, HALT
`ifdef ILLEGAL_OP_TRAP_EN
      , TRAP
`endif
   } state_t;
   typedef enum logic [2:0] {CL_ALU_RR, CL_ALU_IMM, CL_MOV, CL_JMP, CL_NOP, CL_HALT, CL_ILL} opclass_t;
   function automatic opclass_t classify(logic [5:0] op);
      return op[5:4] == 2'b00 ? CL_ALU_RR :
             op[5:4] == 2'b01 ? CL_ALU_IMM :
             op == OP_MOV     ? CL_MOV :
             op == OP_JMP     ? CL_JMP :
             op == OP_NOP     ? CL_NOP :
             op == OP_HALT    ? CL_HALT : CL_ILL;
   endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: fetch, register-file and ALU signals between the sequencer and its neighbours
interface control_sequencer_if;
   import cpu_pkg::*;
   logic [PC_W-1:0]    instr_addr;
   logic               instr_req;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_data;
   logic [7:0]         A1, A2, A3;
   logic               reg_read_en;
   logic               reg_write_en;
   logic [7:0]         write_data;
   logic [FLAG_W-1:0]  flags_out;
   logic [7:0]         rd1, rd2;
   logic [7:0]         op_a, op_b;
   logic [3:0]         alu_op;
   logic [7:0]         alu_result;
   logic [FLAG_W-1:0]  alu_flags;
   logic               halted;
   modport master (
      output instr_addr, instr_req, A1, A2, A3, reg_read_en, reg_write_en, write_data, flags_out,
             op_a, op_b, alu_op, halted,
      input  instr_valid, instr_data, rd1, rd2, alu_result, alu_flags
   );
   modport slave (
      input  instr_addr, instr_req, A1, A2, A3, reg_read_en, reg_write_en, write_data, flags_out,
             op_a, op_b, alu_op, halted,
      output instr_valid, instr_data, rd1, rd2, alu_result, alu_flags
   );
endinterface

// File: rtl/control_sequencer_decoder.sv
// instr_decoder: splits the instruction register into class, register fields, immediate and ALU function
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output opclass_t           cls,
   output logic [REG_AW-1:0]  rd,
   output logic [REG_AW-1:0]  rs1,
   output logic [REG_AW-1:0]  rs2,
   output logic [7:0]         imm,
   output logic [3:0]         alu_op
);
   assign cls    = classify(ir[OP_HI:OP_LO]);
   assign rd     = ir[RD_HI:RD_LO];
   assign rs1    = ir[RS1_HI:RS1_LO];
   assign rs2    = ir[RS2_HI:0];
   assign imm    = ir[IMM_HI:0];
   assign alu_op = ir[OP_LO+3:OP_LO];
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/sequence FSM feeding the register file and ALU (ILLEGAL_OP_TRAP_EN traps illegal opcodes)
module control_sequencer
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   control_sequencer_if.master  bus
);
   state_t             st;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;
   opclass_t           cls;
   logic [REG_AW-1:0]  rd, rs1, rs2;
   logic [7:0]         imm;
   logic [3:0]         dop;

   instr_decoder u_dec (.ir(ir), .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(dop));

   assign bus.instr_addr = pc;

   // instruction sequencing; every bus output is a register updated on the state transition
   always_ff @(posedge clk) begin
      if (reset) begin
         st               <= FETCH;
         pc               <= '0;
         ir               <= '0;
         bus.instr_req    <= 1'b0;
         bus.A1           <= '0;
         bus.A2           <= '0;
         bus.A3           <= '0;
         bus.reg_read_en  <= 1'b0;
         bus.reg_write_en <= 1'b0;
         bus.write_data   <= '0;
         bus.flags_out    <= '0;
         bus.op_a         <= '0;
         bus.op_b         <= '0;
         bus.alu_op       <= '0;
         bus.halted       <= 1'b0;
      end else begin
         case (st)
            FETCH:
               if (bus.instr_req && bus.instr_valid) begin
                  ir            <= bus.instr_data;
                  pc            <= pc + 1'b1;
                  bus.instr_req <= 1'b0;
                  st            <= DECODE;
               end else begin
                  bus.instr_req <= 1'b1;
               end
            DECODE:
               case (cls)
                  CL_ALU_RR, CL_ALU_IMM: begin
                     bus.A1          <= 8'(rs1);
                     bus.A2          <= 8'(rs2);
                     bus.reg_read_en <= 1'b1;
                     bus.alu_op      <= dop;
                     st              <= READ;
                  end
                  CL_MOV: begin
                     bus.write_data   <= imm;
                     bus.A3           <= 8'(rd);
                     bus.reg_write_en <= 1'b1;
                     st               <= WB;
                  end
                  CL_JMP: begin
                     pc            <= imm;
                     bus.instr_req <= 1'b1;
                     st            <= FETCH;
                  end
                  CL_HALT: begin
                     bus.halted <= 1'b1;
                     st         <= HALT;
                  end
`ifdef ILLEGAL_OP_TRAP_EN
                  CL_ILL: begin
                     bus.halted <= 1'b1;
                     st         <= TRAP;
                  end
`endif
                  default: begin
                     bus.instr_req <= 1'b1;
                     st            <= FETCH;
                  end
               endcase
            READ: begin
               bus.op_a        <= bus.rd1;
               bus.op_b        <= cls == CL_ALU_IMM ? imm : bus.rd2;
               bus.reg_read_en <= 1'b0;
               st              <= EXEC;
            end
            EXEC: begin
               bus.write_data   <= bus.alu_result;
               bus.flags_out    <= bus.alu_flags;
               bus.A3           <= 8'(rd);
               bus.reg_write_en <= 1'b1;
               st               <= WB;
            end
            WB: begin
               bus.reg_write_en <= 1'b0;
               bus.instr_req    <= 1'b1;
               st               <= FETCH;
            end
            HALT: st <= HALT;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: st <= TRAP;
`endif
            default: st <= FETCH;
         endcase
      end
   end
endmodule
